updown_counter_param: RTL and testbench

//  Parametrised synchronous up/down counter. Successor to the 4-bit ripple up-counter.
//  - All state bits share one clock edge; no ripple clocking.
//  - Adds: programmable modulus, direction, parallel load, wrap/saturate mode,

---
 rtl/updown_counter_param.sv | 87 ++++++++
 tb/tb_updown_counter_param.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/updown_counter_param.sv
// rtl/updown_counter_param.sv - parametrised synchronous up/down counter with load, saturate, cascade carry and sticky overflow
module updown_counter_param #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf
);

    // Top of the count range, held at register width so compares stay WIDTH bits.
    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);
    localparam bit               SAT   = (SATURATE != 0);

    // Reject parameter sets whose range cannot be represented in WIDTH bits.
    if (WIDTH < 1 || MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_params
        $error("updown_counter_param: illegal WIDTH/MODULUS combination");
    end

    logic [WIDTH-1:0] r_q;
    logic             r_ovf;
    logic [WIDTH-1:0] w_q_next;
    logic             w_at_max;
    logic             w_at_zero;
    logic             w_tc;

    assign w_at_max  = (r_q == MAX_Q);
    assign w_at_zero = (r_q == '0);

    // Terminal count is combinational so a cascaded stage advances on the same edge.
    assign w_tc = en & ~load & ((up & w_at_max) | (~up & w_at_zero));

    // Next count: load (clamped into range) beats counting; range ends wrap or hold.
    always_comb begin
        w_q_next = r_q;
        if (load) begin
            w_q_next = (d > MAX_Q) ? MAX_Q : d;
        end else if (en) begin
            if (up) begin
                if (w_at_max) begin
                    w_q_next = SAT ? r_q : '0;
                end else begin
                    w_q_next = r_q + 1'b1;
                end
            end else begin
                if (w_at_zero) begin
                    w_q_next = SAT ? r_q : MAX_Q;
                end else begin
                    w_q_next = r_q - 1'b1;
                end
            end
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else begin
            r_q <= w_q_next;
        end
    end

    // Sticky overflow: a boundary event sets it and wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_tc) begin
            r_ovf <= 1'b1;
        end else if (clr_ovf) begin
            r_ovf <= 1'b0;
        end
    end

    assign q   = r_q;
    assign tc  = w_tc;
    assign ovf = r_ovf;

endmodule

// File: tb/tb_updown_counter_param.sv
// tb/tb_updown_counter_param.sv - directed self-checking bench for updown_counter_param
module tb_updown_counter_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] d;
    logic       clr_ovf;

    logic [3:0] q_w, q_s, q_f;
    logic       tc_w, tc_s, tc_f;
    logic       ovf_w, ovf_s, ovf_f;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Wrapping, modulus 10
    updown_counter_param #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) dut_w (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .d(d),
        .clr_ovf(clr_ovf), .q(q_w), .tc(tc_w), .ovf(ovf_w)
    );

    // Saturating, modulus 10
    updown_counter_param #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) dut_s (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .d(d),
        .clr_ovf(clr_ovf), .q(q_s), .tc(tc_s), .ovf(ovf_s)
    );

    // Wrapping, full binary range
    updown_counter_param #(.WIDTH(4), .MODULUS(16), .SATURATE(0)) dut_f (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .d(d),
        .clr_ovf(clr_ovf), .q(q_f), .tc(tc_f), .ovf(ovf_f)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int eq;
        int es;
        int ef;
        int eo;
        int eos;

        rst = 1'b1; en = 1'b1; up = 1'b1; load = 1'b1; d = 4'd7; clr_ovf = 1'b0;
        step();
        rst = 1'b0; en = 1'b0; load = 1'b0; d = 4'd0;
        #1;
        chk("reset_q_w", q_w, 0);
        chk("reset_ovf_w", ovf_w, 0);
        chk("reset_tc_w", tc_w, 0);
        chk("reset_q_s", q_s, 0);
        chk("reset_ovf_s", ovf_s, 0);
        chk("reset_q_f", q_f, 0);

        // Up count for 12 cycles: wrap vs saturate vs full range
        en = 1'b1; up = 1'b1;
        #1;
        eq = 0; es = 0; ef = 0; eo = 0; eos = 0;
        for (int i = 0; i < 12; i++) begin
            chk("up_q_w", q_w, eq);
            chk("up_tc_w", tc_w, (eq == 9) ? 1 : 0);
            chk("up_ovf_w", ovf_w, eo);
            chk("up_q_s", q_s, es);
            chk("up_tc_s", tc_s, (es == 9) ? 1 : 0);
            chk("up_ovf_s", ovf_s, eos);
            chk("up_q_f", q_f, ef);
            chk("up_tc_f", tc_f, 0);
            step();
            if (eq == 9) begin eq = 0; eo = 1; end else eq = eq + 1;
            if (es == 9) eos = 1; else es = es + 1;
            ef = ef + 1;
        end
        chk("up_end_q_w", q_w, 2);
        chk("up_end_ovf_w", ovf_w, 1);
        chk("sat_hold_q_s", q_s, 9);
        chk("sat_hold_tc_s", tc_s, 1);
        chk("sat_ovf_s", ovf_s, 1);
        chk("up_end_q_f", q_f, 12);
        chk("up_end_ovf_f", ovf_f, 0);

        // Reverse direction: saturated counter leaves the top, tc drops
        up = 1'b0;
        #1;
        chk("down_tc_s", tc_s, 0);
        chk("down_tc_w", tc_w, 0);
        step();
        chk("down1_q_w", q_w, 1);
        chk("down1_q_s", q_s, 8);
        chk("down1_q_f", q_f, 11);
        step();
        chk("down2_q_w", q_w, 0);
        chk("down2_q_s", q_s, 7);
        chk("down2_tc_w", tc_w, 1);
        chk("down2_tc_s", tc_s, 0);

        // Clear ovf with counting disabled
        en = 1'b0; clr_ovf = 1'b1;
        #1;
        chk("en0_tc_w", tc_w, 0);
        step();
        clr_ovf = 1'b0;
        chk("clr_ovf_w", ovf_w, 0);
        chk("clr_ovf_s", ovf_s, 0);
        chk("clr_q_w", q_w, 0);

        // Down wrap from a loaded 1
        load = 1'b1; d = 4'd1; en = 1'b1; up = 1'b0;
        step();
        load = 1'b0;
        #1;
        chk("dw_q1_w", q_w, 1);
        chk("dw_tc1_w", tc_w, 0);
        step();
        chk("dw_q0_w", q_w, 0);
        chk("dw_tc0_w", tc_w, 1);
        chk("dw_ovf0_w", ovf_w, 0);
        chk("dw_tc0_f", tc_f, 1);
        step();
        chk("dw_q9_w", q_w, 9);
        chk("dw_ovf_w", ovf_w, 1);
        chk("dw_hold_q_s", q_s, 0);
        chk("dw_ovf_s", ovf_s, 1);
        chk("dw_q15_f", q_f, 15);
        chk("dw_ovf_f", ovf_f, 1);
        step();
        chk("dw_q8_w", q_w, 8);
        chk("dw_q14_f", q_f, 14);

        // Load clamp and load-over-enable priority
        load = 1'b1; d = 4'd12; en = 1'b1; up = 1'b1;
        #1;
        chk("load_tc_w", tc_w, 0);
        step();
        chk("clamp_q_w", q_w, 9);
        chk("clamp_q_s", q_s, 9);
        chk("noclamp_q_f", q_f, 12);
        d = 4'd5;
        step();
        chk("load5_q_w", q_w, 5);
        d = 4'd15;
        step();
        chk("load15_q_w", q_w, 9);
        chk("load15_q_f", q_f, 15);
        load = 1'b0;
        #1;
        chk("top_tc_f", tc_f, 1);
        step();
        chk("roll_q_f", q_f, 0);
        chk("roll_q_w", q_w, 0);
        chk("roll_q_s", q_s, 9);

        // Reset mid-count beats load and enable
        load = 1'b1; d = 4'd6;
        step();
        chk("load6_q_w", q_w, 6);
        chk("pre_rst_ovf_w", ovf_w, 1);
        rst = 1'b1; load = 1'b1; d = 4'd3; en = 1'b1; up = 1'b1;
        step();
        chk("midrst_q_w", q_w, 0);
        chk("midrst_ovf_w", ovf_w, 0);
        rst = 1'b0; load = 1'b0;
        step();
        chk("resume_q_w", q_w, 1);

        // ovf set wins over clear, then clear without a boundary
        load = 1'b1; d = 4'd9;
        step();
        load = 1'b0; clr_ovf = 1'b1; en = 1'b1; up = 1'b1;
        #1;
        chk("race_tc_w", tc_w, 1);
        step();
        chk("race_ovf_w", ovf_w, 1);
        chk("race_q_w", q_w, 0);
        step();
        chk("clr_only_ovf_w", ovf_w, 0);
        chk("clr_only_q_w", q_w, 1);
        en = 1'b0; clr_ovf = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("idle_q_w", q_w, 1);
            chk("idle_tc_w", tc_w, 0);
        end
        up = 1'b0; load = 1'b1; d = 4'd0;
        step();
        load = 1'b0;
        #1;
        chk("idle_bound_tc_w", tc_w, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
